// File: rtl/spectrogram_bit_packer_if.sv
// Word stream from the spectrogram bit packer: head-of-buffer word, its frame
// address and last flag, qualified by a valid/ready handshake.
interface spectrogram_bit_packer_if #(
    parameter int WW = 32,
    parameter int AW = 7
);
    logic [WW-1:0] oDATA;
    logic [AW-1:0] oADDR;
    logic          oLAST;
    logic          oVALID;
    logic          iREADY;

    modport master (output oDATA, output oADDR, output oLAST, output oVALID, input iREADY);
    modport slave  (input oDATA, input oADDR, input oLAST, input oVALID, output iREADY);
endinterface

// File: rtl/spectrogram_bit_packer.sv
// Packs the 1-bit detection stream of one frame into WW-bit words and queues
// them in a 2-entry buffer (registered head plus one tail slot) for the writer.
module spectrogram_bit_packer #(
    parameter int WW    = 32,
    parameter int NBITS = 4096,
    parameter int AW    = 7
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iSTART,
    input  logic iEN,
    input  logic iDATA,
    output logic oBUSY,
    output logic oDONE,
    output logic oOVF,
    spectrogram_bit_packer_if.master wordPort
);
    localparam int NWORDS = NBITS / WW;
    localparam int BW     = $clog2(WW);

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

    state_t        state;
    logic [BW-1:0] bitCnt;
    logic [AW-1:0] wordCnt;
    logic [WW-1:0] shiftReg;
    logic [WW-1:0] tailData;
    logic [AW-1:0] tailAddr;
    logic          tailLast;
    logic          tailValid;

    logic          push;
    logic          pop;
    logic          lastWord;
    logic [WW-1:0] pushData;

    // The completing bit is folded into the pushed word on the same edge it arrives.
    assign push     = (state == PACK) && iEN && (bitCnt == {BW{1'b1}});
    assign pop      = wordPort.oVALID && wordPort.iREADY;
    assign lastWord = (wordCnt == AW'(NWORDS - 1));
    assign pushData = {iDATA, shiftReg[WW-2:0]};

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state           <= IDLE;
            bitCnt          <= '0;
            wordCnt         <= '0;
            shiftReg        <= '0;
            tailData        <= '0;
            tailAddr        <= '0;
            tailLast        <= 1'b0;
            tailValid       <= 1'b0;
            wordPort.oDATA  <= '0;
            wordPort.oADDR  <= '0;
            wordPort.oLAST  <= 1'b0;
            wordPort.oVALID <= 1'b0;
            oBUSY           <= 1'b0;
            oDONE           <= 1'b0;
            oOVF            <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state    <= PACK;
                        oBUSY    <= 1'b1;
                        bitCnt   <= '0;
                        wordCnt  <= '0;
                        shiftReg <= '0;
                        oOVF     <= 1'b0;
                    end
                end
                PACK: begin
                    if (iEN) begin
                        shiftReg[bitCnt] <= iDATA;
                        bitCnt           <= bitCnt + 1'b1;
                        if (push) begin
                            // The word index saturates at the final word rather than wrapping.
                            if (lastWord) state <= DRAIN;
                            else          wordCnt <= wordCnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!wordPort.oVALID) begin
                        state <= IDLE;
                        oBUSY <= 1'b0;
                        oDONE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                if (tailValid) begin
                    wordPort.oDATA <= tailData;
                    wordPort.oADDR <= tailAddr;
                    wordPort.oLAST <= tailLast;
                    if (push) begin
                        tailData <= pushData;
                        tailAddr <= wordCnt;
                        tailLast <= lastWord;
                    end else begin
                        tailValid <= 1'b0;
                    end
                end else if (push) begin
                    wordPort.oDATA <= pushData;
                    wordPort.oADDR <= wordCnt;
                    wordPort.oLAST <= lastWord;
                end else begin
                    wordPort.oVALID <= 1'b0;
                end
            end else if (push) begin
                if (!wordPort.oVALID) begin
                    wordPort.oDATA  <= pushData;
                    wordPort.oADDR  <= wordCnt;
                    wordPort.oLAST  <= lastWord;
                    wordPort.oVALID <= 1'b1;
                end else if (!tailValid) begin
                    tailData  <= pushData;
                    tailAddr  <= wordCnt;
                    tailLast  <= lastWord;
                    tailValid <= 1'b1;
                end else begin
                    oOVF <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spectrogram_bit_packer.sv
// Randomized bench for spectrogram_bit_packer: a queue-level frame model is
// compared against the DUT every cycle, with literal expectations pinning it.
module tb_spectrogram_bit_packer;
    localparam int WW     = 32;
    localparam int NBITS  = 96;
    localparam int AW     = 4;
    localparam int NWORDS = NBITS / WW;

    logic clk;
    logic rst;
    logic start;
    logic en;
    logic din;
    logic busy;
    logic done;
    logic ovf;

    spectrogram_bit_packer_if #(.WW(WW), .AW(AW)) bus ();

    spectrogram_bit_packer #(.WW(WW), .NBITS(NBITS), .AW(AW)) dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iSTART  (start),
        .iEN     (en),
        .iDATA   (din),
        .oBUSY   (busy),
        .oDONE   (done),
        .oOVF    (ovf),
        .wordPort(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] d;
        int            a;
        bit            l;
    } ent_t;

    int nChecks = 0;
    int nErr    = 0;
    int doneSeen = 0;

    // Model: frame phase (0 idle, 1 packing, 2 draining), accepted bit count,
    // frame bit vector, bounded word queue and the log of consumed words.
    int             phase;
    int             nb;
    logic [NBITS-1:0] fb;
    ent_t           q[$];
    ent_t           acc[$];
    bit             mOvf;
    bit             mDone;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        phase = 0;
        nb    = 0;
        fb    = '0;
        q.delete();
        mOvf  = 0;
        mDone = 0;
    endtask

    task automatic modelUpdate();
        bit   doPop;
        bit   doPush;
        ent_t e;
        if (rst) begin
            modelReset();
            return;
        end
        mDone  = 0;
        doPop  = (q.size() > 0) && bus.iREADY;
        doPush = 0;
        case (phase)
            0: if (start) begin
                phase = 1;
                nb    = 0;
                fb    = '0;
                mOvf  = 0;
            end
            1: if (en) begin
                fb[nb] = din;
                nb++;
                if (nb % WW == 0) begin
                    doPush = 1;
                    e.d = fb[(nb - WW) +: WW];
                    e.a = nb / WW - 1;
                    e.l = (nb == NBITS);
                    if (nb == NBITS) phase = 2;
                end
            end
            default: if (q.size() == 0) begin
                phase = 0;
                mDone = 1;
            end
        endcase
        if (doPop) begin
            acc.push_back(q[0]);
            void'(q.pop_front());
        end
        if (doPush) begin
            if (q.size() < 2) q.push_back(e);
            else              mOvf = 1;
        end
    endtask

    task automatic compareAll();
        chk("valid", bus.oVALID, q.size() > 0);
        if (q.size() > 0) begin
            chk("data", bus.oDATA, q[0].d);
            chk("addr", bus.oADDR, q[0].a);
            chk("last", bus.oLAST, q[0].l);
        end
        chk("busy", busy, phase != 0);
        chk("done", done, mDone);
        chk("ovf", ovf, mOvf);
        if (done === 1'b1) doneSeen++;
    endtask

    task automatic step();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        compareAll();
    endtask

    task automatic drive(input bit st, input bit e, input bit d, input bit rdy);
        start      = st;
        en         = e;
        din        = d;
        bus.iREADY = rdy;
        step();
    endtask

    // mode 0/1: fixed iREADY, mode 2: iREADY toggles every cycle
    task automatic waitDone(input int mode);
        int s;
        bit r;
        s = doneSeen;
        r = 0;
        for (int i = 0; i < 200; i++) begin
            if (doneSeen != s) break;
            r = (mode == 2) ? ~r : mode[0];
            drive(0, 0, 0, r);
        end
        repeat (3) drive(0, 0, 0, 1);
        chk("done_pulses", doneSeen - s, 1);
    endtask

    task automatic checkWords(input string name, input logic [WW-1:0] w, input bit lastOnFinal, input int n);
        chk({name, "_count"}, acc.size(), n);
        for (int i = 0; i < n && i < acc.size(); i++) begin
            chk({name, "_word"}, acc[i].d, w);
            chk({name, "_addr"}, acc[i].a, i);
            chk({name, "_lastf"}, acc[i].l, lastOnFinal && (i == NWORDS - 1));
        end
    endtask

    initial begin
        bit r;
        int k5;
        modelReset();
        rst = 1'b1; start = 0; en = 0; din = 0; bus.iREADY = 0;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_valid", bus.oVALID, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) drive(0, 1, 1, 1);

        // Alternating bits 1,0,1,0 with a always-ready consumer.
        acc.delete();
        drive(1, 0, 0, 1);
        for (int k = 0; k < NBITS; k++) begin
            drive(0, 1, ~k[0], 1);
            if (k == WW - 1) begin
                chk("t2_lat_valid", bus.oVALID, 1);
                chk("t2_lat_data", bus.oDATA, 32'h5555_5555);
                chk("t2_lat_addr", bus.oADDR, 0);
            end
        end
        waitDone(1);
        checkWords("t2", 32'h5555_5555, 1, NWORDS);
        chk("t2_ovf", ovf, 0);

        // Consumer stalled for the whole frame: third word is dropped.
        acc.delete();
        drive(1, 0, 0, 0);
        for (int k = 0; k < NBITS; k++) drive(0, 1, 1, 0);
        chk("t3_ovf", ovf, 1);
        repeat (4) drive(0, 0, 0, 0);
        chk("t3_busy_stalled", busy, 1);
        waitDone(1);
        checkWords("t3", 32'hFFFF_FFFF, 0, 2);
        chk("t3_ovf_sticky", ovf, 1);

        // Gapped enables with iDATA toggling during gaps, bit k = k[0]^k[3].
        acc.delete();
        drive(1, 0, 0, 1);
        chk("t4_ovf_cleared", ovf, 0);
        for (int k = 0; k < NBITS; k++) begin
            k5 = $urandom_range(0, 5);
            for (int g = 0; g < k5; g++) drive(0, 0, g[0], 1);
            drive(0, 1, k[0] ^ k[3], 1);
        end
        waitDone(1);
        checkWords("t4", 32'h55AA_55AA, 1, NWORDS);

        // Toggling backpressure with random data.
        acc.delete();
        drive(1, 0, 0, 1);
        r = 0;
        for (int k = 0; k < NBITS; k++) begin
            r = ~r;
            drive(0, 1, 1'($urandom), r);
        end
        waitDone(2);
        chk("t5_count", acc.size(), NWORDS);
        for (int i = 0; i < acc.size(); i++) chk("t5_addr", acc[i].a, i);
        chk("t5_ovf", ovf, 0);

        // Asynchronous reset mid-frame, then a clean frame with stray controls.
        drive(1, 0, 0, 1);
        for (int k = 0; k < 40; k++) drive(0, 1, 1'($urandom), 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_valid", bus.oVALID, 0);
        chk("t1_data", bus.oDATA, 0);
        chk("t1_addr", bus.oADDR, 0);
        chk("t1_last", bus.oLAST, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_ovf", ovf, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) drive(0, 1, 1'($urandom), 1);
        acc.delete();
        drive(1, 0, 0, 1);
        for (int k = 0; k < NBITS; k++) drive((k % 7) == 3, 1, (k % WW) < 16, 1);
        waitDone(1);
        checkWords("t6", 32'h0000_FFFF, 1, NWORDS);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
